// File: rtl/execute_muldiv_ctrl_pkg.sv
// rtl/execute_muldiv_ctrl_pkg.sv - shared opcodes and step-mode type for the muldiv sequencer
package execute_muldiv_ctrl_pkg;

    localparam logic [5:0] R_TYPE_OPCODE = 6'h00;
    localparam logic [5:0] MULT_FUNCTION = 6'h18;
    localparam logic [5:0] DIV_FUNCTION  = 6'h1a;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

endpackage

// File: rtl/execute_muldiv_ctrl_muldiv_step.sv
// rtl/execute_muldiv_ctrl_muldiv_step.sv - one radix-2 shift-add / restoring-divide iteration
module muldiv_step
    import execute_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  step_mode_e            mode,
    input  logic [DATA_WIDTH:0]   acc,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH:0]   acc_next,
    output logic [DATA_WIDTH-1:0] op_a_next,
    output logic [DATA_WIDTH-1:0] op_b_next
);

    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  quo_bit;
    logic [DATA_WIDTH-1:0] addend;
    logic                  acc_msb_unused;

    // The remainder never exceeds the divisor, so its top bit is always zero on entry.
    assign acc_msb_unused = acc[DATA_WIDTH];

    always_comb begin
        rem_shift = {acc[DATA_WIDTH-1:0], op_a[DATA_WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, op_b};
        quo_bit   = (rem_shift >= {1'b0, op_b});
        addend    = op_b[0] ? op_a : '0;
        acc_next  = acc;
        op_a_next = op_a;
        op_b_next = op_b;
        if (mode == STEP_MUL) begin
            acc_next  = {1'b0, acc[DATA_WIDTH-1:0] + addend};
            op_a_next = op_a << 1;
            op_b_next = op_b >> 1;
        end else begin
            // op_a shifts dividend bits out the top and quotient bits in at the bottom.
            acc_next  = quo_bit ? rem_diff : rem_shift;
            op_a_next = {op_a[DATA_WIDTH-2:0], quo_bit};
        end
    end

endmodule

// File: rtl/execute_muldiv_ctrl.sv
// rtl/execute_muldiv_ctrl.sv - multi-cycle MULT/DIV sequencer with pipeline stall
module execute_muldiv_ctrl
    import execute_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 6,
    parameter int FUNCTION_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      muldiv_start,
    input  logic [OPCODE_WIDTH-1:0]   muldiv_opcode,
    input  logic [FUNCTION_WIDTH-1:0] muldiv_function,
    input  logic [DATA_WIDTH-1:0]     muldiv_data_in_a,
    input  logic [DATA_WIDTH-1:0]     muldiv_data_in_b,
    input  logic                      muldiv_flush,
    output logic                      muldiv_busy,
    output logic                      muldiv_stall,
    output logic                      muldiv_done,
    output logic                      muldiv_div_by_zero,
    output logic [DATA_WIDTH-1:0]     muldiv_data_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state, state_next;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH:0]   acc_q;
    logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  dbz_q;

    logic                  is_mult, is_div, accept, div_zero, last_iter, iterating;
    step_mode_e            step_mode;
    logic [DATA_WIDTH:0]   acc_next;
    logic [DATA_WIDTH-1:0] op_a_next, op_b_next;

    assign is_mult   = (muldiv_function == FUNCTION_WIDTH'(MULT_FUNCTION));
    assign is_div    = (muldiv_function == FUNCTION_WIDTH'(DIV_FUNCTION));
    assign accept    = (state == IDLE) && muldiv_start &&
                       (muldiv_opcode == OPCODE_WIDTH'(R_TYPE_OPCODE)) && (is_mult || is_div);
    assign div_zero  = is_div && (muldiv_data_in_b == '0);
    assign last_iter = (count == CNT_W'(DATA_WIDTH - 1));
    assign iterating = (state == MUL) || (state == DIV);
    assign step_mode = (state == DIV) ? STEP_DIV : STEP_MUL;

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .mode      (step_mode),
        .acc       (acc_q),
        .op_a      (op_a_q),
        .op_b      (op_b_q),
        .acc_next  (acc_next),
        .op_a_next (op_a_next),
        .op_b_next (op_b_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div_zero)    state_next = DONE;
                    else if (is_div) state_next = DIV;
                    else             state_next = MUL;
                end
            end
            MUL, DIV: if (last_iter) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (muldiv_flush && (state != IDLE)) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            data_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                count  <= '0;
                acc_q  <= '0;
                op_a_q <= muldiv_data_in_a;
                op_b_q <= muldiv_data_in_b;
                if (div_zero) begin
                    data_q <= '1;
                    dbz_q  <= 1'b1;
                end
            end else if (iterating && !muldiv_flush) begin
                count  <= count + 1'b1;
                acc_q  <= acc_next;
                op_a_q <= op_a_next;
                op_b_q <= op_b_next;
                if (last_iter) begin
                    data_q <= (state == MUL) ? acc_next[DATA_WIDTH-1:0] : op_a_next;
                    dbz_q  <= 1'b0;
                end
            end
        end
    end

    assign muldiv_busy        = (state != IDLE);
    assign muldiv_stall       = accept || iterating;
    assign muldiv_done        = (state == DONE);
    assign muldiv_div_by_zero = (state == DONE) && dbz_q;
    assign muldiv_data_out    = data_q;

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// tb/tb_execute_muldiv_ctrl.sv - scoreboard bench for the muldiv sequencer
module tb_execute_muldiv_ctrl;
    import execute_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        muldiv_start;
    logic [5:0]  muldiv_opcode;
    logic [5:0]  muldiv_function;
    logic [31:0] muldiv_data_in_a;
    logic [31:0] muldiv_data_in_b;
    logic        muldiv_flush;
    logic        muldiv_busy;
    logic        muldiv_stall;
    logic        muldiv_done;
    logic        muldiv_div_by_zero;
    logic [31:0] muldiv_data_out;

    typedef struct {
        logic [31:0] data;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_result = '0;

    always #5 clk = ~clk;

    execute_muldiv_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .muldiv_start       (muldiv_start),
        .muldiv_opcode      (muldiv_opcode),
        .muldiv_function    (muldiv_function),
        .muldiv_data_in_a   (muldiv_data_in_a),
        .muldiv_data_in_b   (muldiv_data_in_b),
        .muldiv_flush       (muldiv_flush),
        .muldiv_busy        (muldiv_busy),
        .muldiv_stall       (muldiv_stall),
        .muldiv_done        (muldiv_done),
        .muldiv_div_by_zero (muldiv_div_by_zero),
        .muldiv_data_out    (muldiv_data_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the operation.
    task automatic run_op(input bit op_div, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int intrude_at, input int rst_at);
        exp_t e, g;
        int   done_cyc, stall_bad, abort_at;
        bit   finished;
        abort_at = (flush_at < rst_at) ? flush_at : rst_at;
        e.dbz  = op_div && (b == 0);
        e.data = op_div ? (b == 0 ? 32'hFFFF_FFFF : a / b) : a * b;
        e.lat  = e.dbz ? 1 : 33;
        sb.push_back(e);
        muldiv_start     = 1'b1;
        muldiv_opcode    = R_TYPE_OPCODE;
        muldiv_function  = op_div ? DIV_FUNCTION : MULT_FUNCTION;
        muldiv_data_in_a = a;
        muldiv_data_in_b = b;
        muldiv_flush     = 1'b0;
        rst              = 1'b0;
        done_cyc = -1; stall_bad = 0; finished = 0;
        for (int cyc = 0; cyc <= 40 && !finished; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                muldiv_start = 1'b0;
                muldiv_flush = (cyc == flush_at);
                rst          = (cyc == rst_at);
                if (cyc == intrude_at) begin
                    muldiv_start     = 1'b1;
                    muldiv_function  = MULT_FUNCTION;
                    muldiv_data_in_a = 32'd2;
                    muldiv_data_in_b = 32'd3;
                end
            end
            @(negedge clk);
            if (cyc == 0) begin
                check_eq("idle_at_accept", muldiv_busy, 0);
                check_eq("hold_prior", muldiv_data_out, last_result);
            end
            if (cyc <= abort_at && cyc < e.lat && muldiv_stall !== 1'b1) stall_bad++;
            if (done_cyc >= 0) begin
                check_eq("busy_after_done", muldiv_busy, 0);
                check_eq("done_one_cycle", muldiv_done, 0);
                finished = 1;
            end else if (muldiv_done === 1'b1) begin
                done_cyc = cyc;
                if (sb.size() > 0) begin
                    g = sb.pop_front();
                    check_eq("done_latency", done_cyc, g.lat);
                    check_eq("data_out", muldiv_data_out, g.data);
                    check_eq("div_by_zero", muldiv_div_by_zero, g.dbz);
                    last_result = g.data;
                end
                check_eq("stall_in_done", muldiv_stall, 0);
            end
            if (cyc == abort_at) finished = 1;
        end
        check_eq("stall_run", stall_bad, 0);
        if (abort_at >= 999) begin
            check_eq("done_seen", done_cyc >= 0, 1);
        end else begin
            check_eq("no_done_aborted", done_cyc < 0, 1);
            if (done_cyc < 0 && sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int spurious;
        rst = 1'b1; muldiv_start = 1'b0; muldiv_flush = 1'b0;
        muldiv_opcode = '0; muldiv_function = '0;
        muldiv_data_in_a = '0; muldiv_data_in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", muldiv_busy, 0);
        check_eq("rst_stall", muldiv_stall, 0);
        check_eq("rst_done", muldiv_done, 0);
        check_eq("rst_dbz", muldiv_div_by_zero, 0);
        check_eq("rst_data", muldiv_data_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        muldiv_start = 1'b1; muldiv_opcode = R_TYPE_OPCODE; muldiv_function = 6'h20;
        @(negedge clk);
        check_eq("bad_op_stall", muldiv_stall, 0);
        @(posedge clk); #1;
        muldiv_start = 1'b0;
        @(negedge clk);
        check_eq("bad_op_busy", muldiv_busy, 0);

        @(posedge clk); #1; run_op(0, 32'd7, 32'd6, 999, 999, 999);
        @(posedge clk); #1; run_op(0, 32'hFFFF_FFFF, 32'd2, 999, 999, 999);
        @(posedge clk); #1; run_op(1, 32'd100, 32'd7, 999, 999, 999);
        @(posedge clk); #1; run_op(1, 32'd5, 32'd9, 999, 999, 999);
        @(posedge clk); #1; run_op(1, 32'd123, 32'd0, 999, 999, 999);
        @(posedge clk); #1; run_op(0, 32'd1234, 32'd77, 10, 999, 999);
        @(posedge clk); #1; run_op(1, 32'd9, 32'd3, 999, 999, 999);
        @(posedge clk); #1; run_op(1, 32'd50, 32'd5, 999, 5, 999);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            run_op(i[0], $urandom, $urandom_range(1, 32'hFFFF), 999, 999, 999);
        end
        @(posedge clk); #1; run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 999, 999, 999);

        @(posedge clk); #1; run_op(0, 32'd77, 32'd5, 999, 999, 20);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", muldiv_busy, 0);
        check_eq("midrst_stall", muldiv_stall, 0);
        check_eq("midrst_done", muldiv_done, 0);
        check_eq("midrst_dbz", muldiv_div_by_zero, 0);
        check_eq("midrst_data", muldiv_data_out, 0);
        last_result = '0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (muldiv_done === 1'b1) spurious++;
        end
        check_eq("midrst_no_done", spurious, 0);

        @(posedge clk); #1; run_op(0, 32'd11, 32'd13, 999, 999, 999);
        check_eq("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
